// File: rtl/lsu_data_port.sv
// lsu_data_port: load/store initiator between the CPU memory stage and a
// word-only data BRAM with 1-cycle registered read latency.
//  - Byte/halfword/word RV32 accesses; sub-word stores use read-modify-write.
//  - Loads are lane-extracted (little-endian) and sign/zero extended.
//  - Optional macro LSU_RANGE_CHECK_EN: requests with any of
//    addr[31:ADDR_SIZE+1] set are rejected like misaligned ones. Without it
//    the upper address bits are ignored and addresses alias.
module lsu_data_port #(
  parameter int ADDR_SIZE = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic [31:0] mem_read_addr,
  input  logic [31:0] mem_read_data,
  output logic [31:0] mem_write_addr,
  output logic [31:0] mem_write_data,
  output logic        mem_write_enable
);

  // Reject configurations whose range slice would be empty or reversed.
  if (ADDR_SIZE < 2 || ADDR_SIZE > 30) begin : g_bad_cfg
    $error("lsu_data_port: ADDR_SIZE must be within 2..30");
  end

  typedef enum logic [2:0] {IDLE, RD, CAP, WR, RESP} state_t;

  state_t      state, state_nxt;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q, wdata_q, merge_q;

  logic        req_fire;
  logic        f3_legal, misalign, out_of_range, req_err;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_val, merge_val;

  assign req_fire       = req_valid && req_ready;
  assign mem_write_addr = {addr_q[31:2], 2'b00};

  // Classify the offered request: illegal size, misaligned, or out of range.
  always_comb begin
    if (req_we)
      f3_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                 (req_funct3 == 3'b010);
    else
      f3_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                 (req_funct3 == 3'b010) || (req_funct3 == 3'b100) ||
                 (req_funct3 == 3'b101);
    misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
               ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`ifdef LSU_RANGE_CHECK_EN
    out_of_range = |req_addr[31:ADDR_SIZE+1];
`else
    out_of_range = 1'b0;
`endif
    req_err = !f3_legal || misalign || out_of_range;
  end

  // Lane extraction and sign/zero extension of the returning read word.
  always_comb begin
    byte_sel = mem_read_data[{addr_q[1:0], 3'b000} +: 8];
    half_sel = addr_q[1] ? mem_read_data[31:16] : mem_read_data[15:0];
    case (funct3_q)
      3'b000:  load_val = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_val = {24'd0, byte_sel};
      3'b101:  load_val = {16'd0, half_sel};
      default: load_val = mem_read_data;
    endcase
  end

  // Read-modify-write merge: replace the addressed lane of the read word.
  always_comb begin
    merge_val = mem_read_data;
    if (funct3_q[1:0] == 2'b00)
      merge_val[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    else
      merge_val[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
  end

  // State register; reset aborts any in-flight request.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: errors skip straight to RESP, SW skips the read phase.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (req_fire) begin
              if (req_err)                                state_nxt = RESP;
              else if (req_we && req_funct3[1:0] == 2'b10) state_nxt = WR;
              else                                        state_nxt = RD;
            end
      RD:      state_nxt = CAP;
      CAP:     state_nxt = we_q ? WR : RESP;
      WR:      state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Per-state outputs toward the CPU and the memory.
  always_comb begin
    req_ready        = 1'b0;
    resp_valid       = 1'b0;
    mem_write_enable = 1'b0;
    mem_read_addr    = addr_q;
    mem_write_data   = '0;
    case (state)
      IDLE: begin
        req_ready     = 1'b1;
        mem_read_addr = '0;
      end
      WR: begin
        mem_write_enable = 1'b1;
        mem_write_data   = (funct3_q[1:0] == 2'b10) ? wdata_q : merge_q;
      end
      RESP:    resp_valid = 1'b1;
      default: ;
    endcase
  end

  // Request latch on acceptance; merged store word captured in CAP.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q     <= 1'b0;
      funct3_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      merge_q  <= '0;
    end else begin
      if (req_fire) begin
        we_q     <= req_we;
        funct3_q <= req_funct3;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
      end
      if (state == CAP) merge_q <= merge_val;
    end
  end

  // Response fields load only on entry to RESP and hold afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_err   <= 1'b0;
      resp_rdata <= '0;
    end else if (state != RESP && state_nxt == RESP) begin
      resp_err   <= (state == IDLE);
      resp_rdata <= (state == CAP && !we_q) ? load_val : '0;
    end
  end

endmodule

// File: tb/tb_lsu_data_port.sv
// tb_lsu_data_port: directed test-plan sequence plus randomized traffic
// checked against a byte-level reference memory and latency rules.
module tb_lsu_data_port;
  localparam int ADDR_SIZE = 7;
  localparam int NW        = 2 ** (ADDR_SIZE - 1);
  localparam int REGION    = 2 ** (ADDR_SIZE + 1);

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_read_addr, mem_read_data, mem_write_addr, mem_write_data;
  logic        mem_write_enable;

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] bram [NW];      // environment memory driven by the DUT
  logic [31:0] ref_mem [NW];   // reference contents

  always #5 clk = ~clk;

  lsu_data_port #(.ADDR_SIZE(ADDR_SIZE)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .mem_read_addr(mem_read_addr), .mem_read_data(mem_read_data),
    .mem_write_addr(mem_write_addr), .mem_write_data(mem_write_data),
    .mem_write_enable(mem_write_enable)
  );

  // Word BRAM: registered read, clears on rst.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NW; i++) bram[i] <= '0;
      mem_read_data <= '0;
    end else begin
      if (mem_write_enable) bram[mem_write_addr[ADDR_SIZE:2]] <= mem_write_data;
      mem_read_data <= bram[mem_read_addr[ADDR_SIZE:2]];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic bit ref_err(input logic we, input logic [2:0] f3, input logic [31:0] a);
    int sz;
    bit legal;
    legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    sz = 1 << f3[1:0];
    if (!legal) return 1;
    if (a % sz != 0) return 1;
`ifdef LSU_RANGE_CHECK_EN
    if (a >= REGION) return 1;
`endif
    return 0;
  endfunction

  // Single load/store transaction with full timing and data checks.
  task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd);
    int idx, sh, lat, resp_k, we_k, we_n;
    bit err;
    logic [31:0] word, b, h, exp_rd, exp_wd, mask, got_rd, got_wd, got_wa;
    logic got_err;
    idx  = (a % REGION) / 4;
    sh   = (a % 4) * 8;
    word = ref_mem[idx];
    err  = ref_err(we, f3, a);
    b    = (word >> sh) & 32'hFF;
    h    = (word >> ((a % 4) / 2 * 16)) & 32'hFFFF;
    exp_rd = 0;
    exp_wd = 0;
    if (!err && !we) begin
      case (f3)
        3'd0: exp_rd = (b >= 128) ? (32'hFFFFFF00 | b) : b;
        3'd1: exp_rd = (h >= 32768) ? (32'hFFFF0000 | h) : h;
        3'd4: exp_rd = b;
        3'd5: exp_rd = h;
        default: exp_rd = word;
      endcase
    end
    if (!err && we) begin
      if (f3 == 3'd2) exp_wd = wd;
      else begin
        mask   = (f3 == 3'd0) ? (32'hFF << sh) : (32'hFFFF << ((a % 4) / 2 * 16));
        exp_wd = (word & ~mask) | ((wd << (f3 == 3'd0 ? sh : (a % 4) / 2 * 16)) & mask);
      end
    end
    lat = err ? 1 : (!we ? 3 : (f3 == 3'd2 ? 2 : 4));

    chk("ready_idle", req_ready, 1);
    req_valid = 1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(negedge clk);
    req_valid = 0;
    chk("rd_addr", mem_read_addr, a);
    resp_k = 0; we_k = 0; we_n = 0;
    got_rd = 'x; got_err = 1'bx; got_wd = 'x; got_wa = 'x;
    for (int k = 1; k <= 8 && resp_k == 0; k++) begin
      if (k > 1) @(negedge clk);
      if (mem_write_enable) begin
        we_n++; we_k = k; got_wd = mem_write_data; got_wa = mem_write_addr;
      end
      if (resp_valid) begin
        resp_k = k; got_err = resp_err; got_rd = resp_rdata;
      end
    end
    chk("resp_cycle", resp_k, lat);
    chk("resp_err", {31'd0, got_err}, {31'd0, err});
    chk("resp_rdata", got_rd, exp_rd);
    chk("we_count", we_n, (we && !err) ? 1 : 0);
    if (we && !err) begin
      chk("we_cycle", we_k, lat - 1);
      chk("wr_addr", got_wa, {a[31:2], 2'b00});
      chk("wr_data", got_wd, exp_wd);
      ref_mem[idx] = exp_wd;
    end
    @(negedge clk);
    chk("ready_after", req_ready, 1);
    chk("resp_pulse", resp_valid, 0);
    chk("resp_hold", resp_rdata, exp_rd);
  endtask

  initial begin
    logic [31:0] a;
    logic [2:0]  f3;
    logic        we;
    rst = 1; req_valid = 0; req_we = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0;
    for (int i = 0; i < NW; i++) ref_mem[i] = '0;
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("rst_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_err", resp_err, 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    chk("rst_we", mem_write_enable, 0);
    chk("rst_wdata", mem_write_data, 0);
    chk("rst_raddr", mem_read_addr, 0);

    // Directed sequence
    xact(1, 3'd2, 32'h10, 32'hDEADBEEF);
    xact(0, 3'd2, 32'h10, 0);
    xact(1, 3'd0, 32'h11, 32'h80);
    xact(0, 3'd2, 32'h10, 0);
    xact(0, 3'd0, 32'h11, 0);
    xact(0, 3'd4, 32'h11, 0);
    xact(1, 3'd1, 32'h12, 32'hF234);
    xact(0, 3'd2, 32'h10, 0);
    xact(0, 3'd1, 32'h12, 0);
    xact(0, 3'd5, 32'h12, 0);
    xact(0, 3'd2, 32'h13, 0);
    xact(1, 3'd1, 32'h11, 32'h1111);
    xact(0, 3'd3, 32'h10, 0);
    xact(1, 3'd3, 32'h10, 32'h5);
    xact(0, 3'd2, 32'h10, 0);
    chk("plan_word", ref_mem[4], 32'hF23480EF);
    xact(1, 3'd2, 32'h00, 32'h12345678);
    xact(0, 3'd2, 32'h100, 0);

    // Back-to-back loads with req_valid held high
    req_valid = 1; req_we = 0; req_funct3 = 3'd2; req_addr = 32'h10;
    @(negedge clk);
    for (int k = 1; k <= 3; k++) begin
      chk("b2b_busy", req_ready, 0);
      if (k == 3) begin
        chk("b2b_resp1", resp_valid, 1);
        chk("b2b_data1", resp_rdata, ref_mem[4]);
      end
      @(negedge clk);
    end
    chk("b2b_ready", req_ready, 1);
    req_addr = 32'h00;
    @(negedge clk);
    req_valid = 0;
    chk("b2b_accept", req_ready, 0);
    @(negedge clk);
    @(negedge clk);
    chk("b2b_resp2", resp_valid, 1);
    chk("b2b_data2", resp_rdata, ref_mem[0]);
    @(negedge clk);

    // Reset while a sub-word store sits in CAP
    req_valid = 1; req_we = 1; req_funct3 = 3'd0; req_addr = 32'h11; req_wdata = 32'h55;
    @(negedge clk);
    req_valid = 0;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("rst_abort_we", mem_write_enable, 0);
    chk("rst_abort_resp", resp_valid, 0);
    chk("rst_abort_ready", req_ready, 1);
    rst = 0;
    for (int i = 0; i < NW; i++) ref_mem[i] = '0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("post_rst_we", mem_write_enable, 0);
      chk("post_rst_resp", resp_valid, 0);
    end
    xact(0, 3'd2, 32'h10, 0);

    // Randomized traffic
    for (int t = 0; t < 200; t++) begin
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) f3 = {1'b0, 2'($urandom_range(0, 2))} | (we ? 3'd0 : {1'($urandom_range(0,1)), 2'd0});
      a = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 2 * REGION - 1));
      if ($urandom_range(0, 1) == 1 && f3[1:0] != 2'b00) a = a & ~32'(f3[1:0] == 2'b01 ? 1 : 3);
      xact(we, f3, a, $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // Overall time bound
  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/lsu_data_port.md
Name: lsu_data_port

Overview:
- Load/store initiator between the CPU memory stage and the word-only data BRAM.
- Accepts one load or store per handshake. Implements RV32 byte, halfword and word access on top of a memory that stores only 32-bit words, indexes by addr[ADDR_SIZE:2] and has 1-cycle registered read latency.
- Sub-word stores are done as read-modify-write. Loads are lane-extracted and sign- or zero-extended.

Parameters:
- ADDR_SIZE, 7: top byte-address bit used by the memory. Addressable region is 2**(ADDR_SIZE+1) bytes.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request (high only in IDLE)
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32 funct3 access size/sign
- req_addr  in  32  byte address
- req_wdata  in  32  store data; low bits used for SB/SH
- resp_valid  out  1  one-cycle completion pulse; no backpressure
- resp_err  out  1  request rejected (misaligned, illegal funct3, or out of range)
- resp_rdata  out  32  load result; 0 for stores and errors
- mem_read_addr  out  32  to memory read_addr
- mem_read_data  in  32  from memory read_data; valid the cycle after the address is presented
- mem_write_addr  out  32  to memory write_addr
- mem_write_data  out  32  to memory write_data
- mem_write_enable  out  1  to memory write_enable

Behaviour:
- Handshake: accept when req_valid && req_ready at a clock edge. Latch we, funct3, addr, wdata into addr_q etc. Requests offered while busy are not accepted.
- States: IDLE, RD, CAP, WR, RESP.
- Legal loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- Legal stores: 000 SB, 001 SH, 010 SW.
- Any other funct3 is illegal.
- Misaligned: H access with addr[0]=1; W access with addr[1:0]!=0.
- Timing, with acceptance in cycle n:
  - Error: IDLE→RESP. resp_valid=1, resp_err=1, resp_rdata=0 in cycle n+1. Memory is never written.
  - Load: RD (n+1), CAP (n+2), RESP (n+3).
  - SW: WR (n+1), RESP (n+2).
  - SB/SH: RD (n+1), CAP (n+2), WR (n+3), RESP (n+4).
  - RESP→IDLE always. req_ready returns high in the cycle after RESP.
- mem_read_addr = addr_q in all states except IDLE, where it is 0.
- mem_write_addr = {addr_q[31:2],2'b00}.
- mem_write_enable is high only in WR, for exactly one cycle.
- CAP, load: register the extracted lane, little-endian.
  - Byte lane = addr_q[1:0]; half lane = addr_q[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word unchanged.
- CAP, SB/SH: register the merged word = mem_read_data with the addressed lane replaced by wdata[7:0] or wdata[15:0]. In WR, mem_write_data is this merged word.
- SW: mem_write_data = wdata_q, unmodified.
- resp_rdata and resp_err update only on entry to RESP and hold their value afterwards. resp_valid is high only in RESP.
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_write_enable=0, mem_write_data=0, mem_read_addr=0.
- Reset mid-operation: abort in any state. No write is issued even if reset arrives in CAP. No resp_valid is produced for the aborted request. The memory also clears itself on rst.
- Upper address bits: ignored when the optional feature is off, so addresses alias modulo 2**(ADDR_SIZE+1).

Optional Feature:
- Macro: LSU_RANGE_CHECK_EN.
- Defined: a request with any of addr[31:ADDR_SIZE+1] nonzero is an error, using the same error path and timing as misalignment. Range check and misalignment are combined by OR.
- Undefined: no range check; upper address bits are ignored.

Test Plan:
- SW 0xDEADBEEF @0x10 (cycle n) → mem_write_enable high only in n+1, resp_valid in n+2. Then LW @0x10 → resp_rdata=0xDEADBEEF, resp_valid in n'+3.
- SB wdata=0x80 @0x11 over 0xDEADBEEF → memory word 0xDEAD80EF, resp_valid in n+4. LB @0x11 → 0xFFFFFF80. LBU @0x11 → 0x00000080.
- SH wdata=0xF234 @0x12 → LW @0x10 = 0xF23480EF. LH @0x12 → 0xFFFFF234. LHU @0x12 → 0x0000F234.
- LW @0x13, SH @0x11, and load funct3=011 → each gives resp_err=1 and resp_rdata=0 in n+1, no memory write. LW @0x10 afterwards is unchanged.
- Assert rst while an SB is in CAP → no mem_write_enable, no resp_valid. After rst deasserts: req_ready=1, state IDLE, LW @0x10 returns 0.
- req_valid held high through back-to-back LWs → req_ready low from n+1 to n+3, second request accepted in n+4.
- With LSU_RANGE_CHECK_EN and ADDR_SIZE=7: LW @0x100 → resp_err=1. Without the macro it returns the word at 0x00.
